exe_mem_stage: RTL and testbench
================================

// Module: exe_mem_stage
// PURPOSE
//  Consumer end of the ID/EXE pipeline interface. Accepts the decoded bundle (ir, pc, extended
//  immediate, operands, alu_func, alu_in2_select) over a valid/ready handshake, executes the ALU
//  operation and presents the EXE/MEM bundle downstream. A one-entry skid buffer sustains one
//  instruction per cycle under back-pressure. Also drives the EXE-stage forwarding source.
// PARAMETERS
//  XLEN       32  datapath width (ir/pc fixed at 32)
//  SKID_EN    1   1 = skid buffer present; 0 = in_ready = out_ready || !out_valid
// PORTS
//  clk            in   1     rising-edge clock
//  rst_n          in   1     asynchronous active-low reset
//  in_valid       in   1     ID/EXE bundle valid
//  in_ready       out  1     stage can accept bundle this cycle
//  ir_exe         in   32    instruction word
//  pc_exe         in   32    instruction pc
//  extend_exe     in   XLEN  sign-extended immediate
//  reg1_exe       in   XLEN  operand A
//  reg2_exe       in   XLEN  operand B / store data
//  alu_func_exe   in   3     ALU function
//  alu_in2_select in   1     1 = ALU B input is extend_exe
//  flush          in   1     discard everything held and the input this cycle
//  out_valid      out  1     EXE/MEM bundle valid
//  out_ready      in   1     MEM stage accepts bundle
//  ir_mem         out  32    instruction word
//  pc_mem         out  32    pc
//  alu_out_mem    out  XLEN  ALU result (address for loads)
//  reg2_mem       out  XLEN  operand B passthrough
//  rd_mem         out  5     destination register
//  wen_mem        out  1     register write enable
//  mem_rd_mem     out  1     load (opcode 100000)
//  fwd_valid      out  1     out_valid && wen_mem && rd_mem!=0
//  fwd_rd         out  5     = rd_mem
//  fwd_data       out  XLEN  = alu_out_mem
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, skid empty, all data outputs 0, in_ready=1 after release.
//  ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed, result 0/1), 110 add (imm),
//   111 add (load address). B = alu_in2_select ? extend_exe : reg2_exe. Wrap-around modulo 2^XLEN,
//   no overflow trap.
//  Decode: opcode ir[31:26]: 000100 R-type rd=ir[15:11]; 000010/100000 rd=ir[20:16]; wen=1 for
//   these three, else wen=0, rd=0. mem_rd=1 only for 100000.
//  Transfer: accept when in_valid && in_ready; result registered, out_valid next cycle (latency 1).
//  Output register loads when !out_valid || out_ready. If out held (out_valid && !out_ready) and a
//   bundle is accepted, it goes to skid; in_ready=0 while skid full. On out_ready, skid moves to
//   output before any new input; in_ready returns 1 the following cycle.
//  Order preserved; no bundle dropped or duplicated except by flush.
//  flush=1: next cycle out_valid=0, skid empty; in_valid ignored that cycle. flush wins over all.
//  out_valid with !out_ready: all out_*/fwd_* stable.
//  rst_n asserted mid-transfer: state cleared immediately; outputs revert to reset values.
//  SKID_EN=0: no skid register; in_ready combinational from out_ready.
// STRUCTURE
//  Package cpu_defs_pkg: opcode constants (OP_RTYPE=6'b000100, OP_IMM=6'b000010, OP_LW=6'b100000),
//   ALU function enum (3 bits), exe_mem bundle struct.
//  Sub-module exe_alu: combinational ALU (a, b, func -> y). Top: decode, skid, output register.
// TESTING
//  R-type add: reg1=5, reg2=7, func 000, ir rd=3 -> next cycle out_valid=1, alu_out=12, rd=3, wen=1.
//  Load: ir op=100000 rt=9, reg1=0x1000, extend=0xFFFFFFFC, sel=1 -> alu_out=0x00000FFC, mem_rd=1, rd=9.
//  slt signed: reg1=0xFFFFFFFF, reg2=1, func 101 -> alu_out=1; swap operands -> 0.
//  Back-pressure: out_ready=0 for 3 cycles with in_valid=1 every cycle -> exactly 2 accepted, in_ready=0,
//   outputs stable; release -> both emerge in order, no loss.
//  Flush with skid full -> next cycle out_valid=0, in_ready=1, nothing later emitted.
//  rst_n low mid-stream -> out_valid=0 asynchronously; fwd_valid=0; rd with rd=0 never sets fwd_valid.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the EXE stage: opcodes, ALU function codes, EXE/MEM header bundle.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cpu_defs_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000100;
    localparam logic [5:0] OP_IMM   = 6'b000010;
    localparam logic [5:0] OP_LW    = 6'b100000;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SLT  = 3'b101,
        ALU_ADDI = 3'b110,
        ALU_ADDL = 3'b111
    } alu_func_e;

    // Width-independent part of the EXE/MEM bundle; XLEN-wide data travels alongside it.
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wen;
        logic        mem_rd;
    } exe_mem_hdr_t;

    // Destination register, write enable and load flag are all derived from the opcode.
    function automatic exe_mem_hdr_t decode_hdr(input logic [31:0] ir, input logic [31:0] pc);
        exe_mem_hdr_t h;
        h.ir     = ir;
        h.pc     = pc;
        h.rd     = 5'd0;
        h.wen    = 1'b0;
        h.mem_rd = 1'b0;
        case (ir[31:26])
            OP_RTYPE: begin
                h.rd  = ir[15:11];
                h.wen = 1'b1;
            end
            OP_IMM: begin
                h.rd  = ir[20:16];
                h.wen = 1'b1;
            end
            OP_LW: begin
                h.rd     = ir[20:16];
                h.wen    = 1'b1;
                h.mem_rd = 1'b1;
            end
            default: ;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU for the EXE stage; arithmetic wraps modulo 2^XLEN, slt is signed.
// Latency: 0 cycles (pure combinational).
// Backpressure: none, no state.
module exe_alu
    import cpu_defs_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  alu_func_e       i_func,
    output logic [XLEN-1:0] o_y
);

    logic w_lt;
    assign w_lt = ($signed(i_a) < $signed(i_b));

    // Select the operation; both add-style immediate/load codes share the adder.
    always_comb begin
        o_y = '0;
        case (i_func)
            ALU_ADD, ALU_ADDI, ALU_ADDL: o_y = i_a + i_b;
            ALU_SUB:                     o_y = i_a - i_b;
            ALU_AND:                     o_y = i_a & i_b;
            ALU_OR:                      o_y = i_a | i_b;
            ALU_XOR:                     o_y = i_a ^ i_b;
            ALU_SLT:                     o_y = {{(XLEN-1){1'b0}}, w_lt};
            default:                     o_y = '0;
        endcase
    end

endmodule

// File: rtl/exe_mem_stage.sv
// EXE stage: accepts ID/EXE bundle, runs the ALU, registers the EXE/MEM bundle and forwarding source.
// Latency: 1 cycle from accepted input to out_valid.
// Backpressure: one-entry skid absorbs one bundle while output is held; in_ready low while skid full.
module exe_mem_stage
    import cpu_defs_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     ir_exe,
    input  logic [31:0]     pc_exe,
    input  logic [XLEN-1:0] extend_exe,
    input  logic [XLEN-1:0] reg1_exe,
    input  logic [XLEN-1:0] reg2_exe,
    input  logic [2:0]      alu_func_exe,
    input  logic            alu_in2_select,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     ir_mem,
    output logic [31:0]     pc_mem,
    output logic [XLEN-1:0] alu_out_mem,
    output logic [XLEN-1:0] reg2_mem,
    output logic [4:0]      rd_mem,
    output logic            wen_mem,
    output logic            mem_rd_mem,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
);

    exe_mem_hdr_t    w_in_hdr;
    logic [XLEN-1:0] w_alu_b;
    logic [XLEN-1:0] w_alu_y;
    logic            w_out_load;
    logic            w_accept;
    logic            w_skid_load;

    logic            r_out_vld;
    exe_mem_hdr_t    r_out_hdr;
    logic [XLEN-1:0] r_out_alu;
    logic [XLEN-1:0] r_out_reg2;

    logic            r_skid_vld;
    exe_mem_hdr_t    r_skid_hdr;
    logic [XLEN-1:0] r_skid_alu;
    logic [XLEN-1:0] r_skid_reg2;

    assign w_in_hdr = decode_hdr(ir_exe, pc_exe);
    assign w_alu_b  = alu_in2_select ? extend_exe : reg2_exe;

    exe_alu #(.XLEN(XLEN)) u_alu (
        .i_a    (reg1_exe),
        .i_b    (w_alu_b),
        .i_func (alu_func_e'(alu_func_exe)),
        .o_y    (w_alu_y)
    );

    // Output register is free when empty or being drained this cycle.
    assign w_out_load = !r_out_vld || out_ready;

    generate
        if (SKID_EN) begin : g_skid_rdy
            // Registered ready: only depends on skid occupancy, breaks the out_ready path.
            assign in_ready = !r_skid_vld;
        end else begin : g_noskid_rdy
            assign in_ready = w_out_load;
        end
    endgenerate

    assign w_accept    = in_valid && in_ready && !flush;
    assign w_skid_load = SKID_EN && w_accept && !w_out_load;

    // Output register: skid content has priority over fresh input to keep order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_hdr  <= '0;
            r_out_alu  <= '0;
            r_out_reg2 <= '0;
        end else if (flush) begin
            r_out_vld <= 1'b0;
        end else if (w_out_load) begin
            if (r_skid_vld) begin
                r_out_vld  <= 1'b1;
                r_out_hdr  <= r_skid_hdr;
                r_out_alu  <= r_skid_alu;
                r_out_reg2 <= r_skid_reg2;
            end else if (w_accept) begin
                r_out_vld  <= 1'b1;
                r_out_hdr  <= w_in_hdr;
                r_out_alu  <= w_alu_y;
                r_out_reg2 <= reg2_exe;
            end else begin
                r_out_vld <= 1'b0;
            end
        end
    end

    // Skid register: captures a bundle accepted while the output is held, empties when output loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_vld  <= 1'b0;
            r_skid_hdr  <= '0;
            r_skid_alu  <= '0;
            r_skid_reg2 <= '0;
        end else if (flush) begin
            r_skid_vld <= 1'b0;
        end else if (w_skid_load) begin
            r_skid_vld  <= 1'b1;
            r_skid_hdr  <= w_in_hdr;
            r_skid_alu  <= w_alu_y;
            r_skid_reg2 <= reg2_exe;
        end else if (w_out_load) begin
            r_skid_vld <= 1'b0;
        end
    end

    assign out_valid   = r_out_vld;
    assign ir_mem      = r_out_hdr.ir;
    assign pc_mem      = r_out_hdr.pc;
    assign alu_out_mem = r_out_alu;
    assign reg2_mem    = r_out_reg2;
    assign rd_mem      = r_out_hdr.rd;
    assign wen_mem     = r_out_hdr.wen;
    assign mem_rd_mem  = r_out_hdr.mem_rd;

    // Writes to r0 are architecturally discarded, so they never forward.
    assign fwd_valid = r_out_vld && r_out_hdr.wen && (r_out_hdr.rd != 5'd0);
    assign fwd_rd    = r_out_hdr.rd;
    assign fwd_data  = r_out_alu;

endmodule

// File: tb/tb_exe_mem_stage.sv
module tb_exe_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ir_exe;
    logic [31:0] pc_exe;
    logic [31:0] extend_exe;
    logic [31:0] reg1_exe;
    logic [31:0] reg2_exe;
    logic [2:0]  alu_func_exe;
    logic        alu_in2_select;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ir_mem;
    logic [31:0] pc_mem;
    logic [31:0] alu_out_mem;
    logic [31:0] reg2_mem;
    logic [4:0]  rd_mem;
    logic        wen_mem;
    logic        mem_rd_mem;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    exe_mem_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .ir_exe         (ir_exe),
        .pc_exe         (pc_exe),
        .extend_exe     (extend_exe),
        .reg1_exe       (reg1_exe),
        .reg2_exe       (reg2_exe),
        .alu_func_exe   (alu_func_exe),
        .alu_in2_select (alu_in2_select),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .ir_mem         (ir_mem),
        .pc_mem         (pc_mem),
        .alu_out_mem    (alu_out_mem),
        .reg2_mem       (reg2_mem),
        .rd_mem         (rd_mem),
        .wen_mem        (wen_mem),
        .mem_rd_mem     (mem_rd_mem),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data)
    );

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] ext,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [2:0] f,
                         input logic sel);
        ir_exe         = ir;
        pc_exe         = pc;
        extend_exe     = ext;
        reg1_exe       = r1;
        reg2_exe       = r2;
        alu_func_exe   = f;
        alu_in2_select = sel;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ir_r(input logic [4:0] rd);
        return {6'b000100, 5'd1, 5'd2, rd, 11'd0};
    endfunction

    function automatic logic [31:0] ir_i(input logic [5:0] op, input logic [4:0] rt);
        return {op, 5'd0, rt, 16'h0004};
    endfunction

    initial begin : stim
        int acc;
        int emitted;
        logic can;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush    = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0);

        // Reset state
        #12;
        chk_eq("rst_out_valid", out_valid, 0);
        chk_eq("rst_fwd_valid", fwd_valid, 0);
        chk_eq("rst_alu_out", alu_out_mem, 0);
        chk_eq("rst_ir_mem", ir_mem, 0);
        chk_eq("rst_rd_wen", {rd_mem, wen_mem, mem_rd_mem}, 0);
        #1 rst_n = 1'b1;
        tick();
        chk_eq("rst_in_ready", in_ready, 1);

        // R-type add: 5 + 7 -> rd 3
        drive(ir_r(5'd3), 32'h40, 32'd0, 32'd5, 32'd7, 3'b000, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_eq("add_valid", out_valid, 1);
        chk_eq("add_alu", alu_out_mem, 12);
        chk_eq("add_rd", rd_mem, 3);
        chk_eq("add_wen", wen_mem, 1);
        chk_eq("add_memrd", mem_rd_mem, 0);
        chk_eq("add_pc", pc_mem, 32'h40);
        chk_eq("add_reg2", reg2_mem, 7);
        chk_eq("add_fwd", {fwd_valid, fwd_rd, fwd_data}, {1'b1, 5'd3, 32'd12});
        tick();
        chk_eq("drain_valid", out_valid, 0);

        // Load address: 0x1000 + 0xFFFFFFFC
        drive(ir_i(6'b100000, 5'd9), 32'h44, 32'hFFFF_FFFC, 32'h1000, 32'h55, 3'b111, 1'b1);
        in_valid = 1'b1;
        tick();
        chk_eq("lw_alu", alu_out_mem, 32'h0000_0FFC);
        chk_eq("lw_memrd", mem_rd_mem, 1);
        chk_eq("lw_rd", rd_mem, 9);
        chk_eq("lw_wen", wen_mem, 1);
        chk_eq("lw_reg2", reg2_mem, 32'h55);

        // Back-to-back: slt signed both ways, sub into r0, unknown opcode, addi
        drive(ir_r(5'd4), 32'h48, 32'd0, 32'hFFFF_FFFF, 32'd1, 3'b101, 1'b0);
        tick();
        chk_eq("slt_neg_lt", alu_out_mem, 1);
        drive(ir_r(5'd4), 32'h4C, 32'd0, 32'd1, 32'hFFFF_FFFF, 3'b101, 1'b0);
        tick();
        chk_eq("slt_swap", alu_out_mem, 0);
        drive(ir_r(5'd0), 32'h50, 32'd0, 32'd5, 32'd7, 3'b001, 1'b0);
        tick();
        chk_eq("sub_wrap", alu_out_mem, 32'hFFFF_FFFE);
        chk_eq("sub_r0_wen", {rd_mem, wen_mem}, {5'd0, 1'b1});
        chk_eq("r0_no_fwd", fwd_valid, 0);
        drive(ir_i(6'b111111, 5'd9), 32'h54, 32'd0, 32'h0000_F0F0, 32'h0000_FF00, 3'b010, 1'b0);
        tick();
        chk_eq("and_alu", alu_out_mem, 32'h0000_F000);
        chk_eq("unk_rd_wen", {rd_mem, wen_mem, mem_rd_mem}, 0);
        chk_eq("unk_no_fwd", fwd_valid, 0);
        drive(ir_i(6'b000010, 5'd7), 32'h58, 32'hFFFF_FFFF, 32'd10, 32'd0, 3'b110, 1'b1);
        tick();
        chk_eq("addi_alu", alu_out_mem, 9);
        chk_eq("addi_rd", rd_mem, 7);
        chk_eq("addi_fwd", fwd_valid, 1);
        drive(ir_r(5'd5), 32'h5C, 32'd0, 32'h0F0F_0000, 32'h00FF_0000, 3'b100, 1'b0);
        tick();
        in_valid = 1'b0;
        chk_eq("xor_alu", alu_out_mem, 32'h0FF0_0000);
        drive(ir_r(5'd5), 32'h60, 32'd0, 32'h0F0F_0000, 32'h00FF_0000, 3'b011, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_eq("or_alu", alu_out_mem, 32'h0FFF_0000);
        tick();
        chk_eq("idle_before_bp", out_valid, 0);

        // Back-pressure: 3 cycles held with in_valid high
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            drive(ir_r(5'd1), 32'h100 + 32'(acc * 4), 32'd0, 32'(acc) + 32'd10, 32'd1, 3'b000, 1'b0);
            in_valid = 1'b1;
            can = in_ready;
            tick();
            if (can) acc++;
        end
        chk_eq("bp_accepted", 64'(acc), 2);
        chk_eq("bp_in_ready", in_ready, 0);
        chk_eq("bp_held_valid", out_valid, 1);
        chk_eq("bp_held_pc", pc_mem, 32'h100);
        chk_eq("bp_held_alu", alu_out_mem, 11);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_eq("bp_second_valid", out_valid, 1);
        chk_eq("bp_second_pc", pc_mem, 32'h104);
        chk_eq("bp_second_alu", alu_out_mem, 12);
        chk_eq("bp_ready_back", in_ready, 1);
        tick();
        chk_eq("bp_no_extra", out_valid, 0);

        // Flush with skid full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(ir_r(5'd2), 32'h200, 32'd0, 32'd1, 32'd1, 3'b000, 1'b0);
        tick();
        drive(ir_r(5'd2), 32'h204, 32'd0, 32'd2, 32'd1, 3'b000, 1'b0);
        tick();
        chk_eq("fl_skid_full", in_ready, 0);
        drive(ir_r(5'd2), 32'h208, 32'd0, 32'd3, 32'd1, 3'b000, 1'b0);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_eq("fl_out_valid", out_valid, 0);
        chk_eq("fl_in_ready", in_ready, 1);
        chk_eq("fl_fwd", fwd_valid, 0);
        out_ready = 1'b1;
        emitted = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid) emitted++;
        end
        chk_eq("fl_nothing_later", 64'(emitted), 0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        drive(ir_r(5'd6), 32'h300, 32'd0, 32'd3, 32'd4, 3'b000, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_eq("ar_pre_fwd", {fwd_valid, fwd_data}, {1'b1, 32'd7});
        #3 rst_n = 1'b0;
        #1;
        chk_eq("ar_out_valid", out_valid, 0);
        chk_eq("ar_fwd_valid", fwd_valid, 0);
        chk_eq("ar_data_cleared", {alu_out_mem, rd_mem, pc_mem}, 0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk_eq("ar_in_ready", in_ready, 1);
        chk_eq("ar_stays_idle", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
